// File: rtl/coffe_dispenser.sv
// rtl/coffe_dispenser.sv - timed actuator sequencer for product motors, coin ejector and escrow gate
module coffe_dispenser #(
  parameter int MOTOR_CYCLES  = 50,
  parameter int EJECT_CYCLES  = 10,
  parameter int GAP_CYCLES    = 5,
  parameter int ESCROW_CYCLES = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       out_en,
  input  logic [3:0] out,
  input  logic       change_en,
  input  logic [1:0] change,
  input  logic       return_req,
  output logic [3:0] motor,
  output logic       coin_eject,
  output logic       escrow_gate,
  output logic       busy,
  output logic       done,
  output logic       fault
);

  localparam int MAX_AB  = (MOTOR_CYCLES > EJECT_CYCLES) ? MOTOR_CYCLES : EJECT_CYCLES;
  localparam int MAX_CD  = (GAP_CYCLES > ESCROW_CYCLES) ? GAP_CYCLES : ESCROW_CYCLES;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int TW      = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    IDLE, VEND, EJECT, GAP, REFUND, DONE
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [3:0]    sel, sel_nxt;
  logic [1:0]    coins, coins_nxt;
  logic          fault_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= '0;
      sel         <= '0;
      coins       <= '0;
      motor       <= '0;
      coin_eject  <= 1'b0;
      escrow_gate <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      sel         <= sel_nxt;
      coins       <= coins_nxt;
      // Outputs are registered copies of what the next state will drive.
      motor       <= (state_nxt == VEND) ? sel_nxt : 4'b0000;
      coin_eject  <= (state_nxt == EJECT);
      escrow_gate <= (state_nxt == REFUND);
      busy        <= (state_nxt != IDLE);
      done        <= (state_nxt == DONE);
      fault       <= fault_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    sel_nxt   = sel;
    coins_nxt = coins;
    fault_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (out_en || change_en) begin
          sel_nxt   = out_en ? out : 4'b0000;
          coins_nxt = change_en ? change : 2'd0;
          fault_nxt = out_en && !$onehot(out);
          if (out_en && $onehot(out)) begin
            state_nxt = VEND;
            timer_nxt = TW'(MOTOR_CYCLES - 1);
          end else if (coins_nxt != 2'd0) begin
            // Count is decremented on entry to each eject.
            state_nxt = EJECT;
            timer_nxt = TW'(EJECT_CYCLES - 1);
            coins_nxt = coins_nxt - 2'd1;
          end else begin
            state_nxt = DONE;
          end
        end else if (return_req) begin
          state_nxt = REFUND;
          timer_nxt = TW'(ESCROW_CYCLES - 1);
        end
      end
      VEND: begin
        if (timer != '0) begin
          timer_nxt = timer - TW'(1);
        end else if (coins != 2'd0) begin
          state_nxt = EJECT;
          timer_nxt = TW'(EJECT_CYCLES - 1);
          coins_nxt = coins - 2'd1;
        end else begin
          state_nxt = DONE;
        end
      end
      EJECT: begin
        if (timer != '0) begin
          timer_nxt = timer - TW'(1);
        end else if (coins != 2'd0) begin
          state_nxt = GAP;
          timer_nxt = TW'(GAP_CYCLES - 1);
        end else begin
          state_nxt = DONE;
        end
      end
      GAP: begin
        if (timer != '0) begin
          timer_nxt = timer - TW'(1);
        end else begin
          state_nxt = EJECT;
          timer_nxt = TW'(EJECT_CYCLES - 1);
          coins_nxt = coins - 2'd1;
        end
      end
      REFUND: begin
        if (timer != '0) timer_nxt = timer - TW'(1);
        else state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
        sel_nxt   = '0;
        coins_nxt = '0;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_coffe_dispenser.sv
// tb/tb_coffe_dispenser.sv - randomized check of coffe_dispenser against a per-cycle waveform model
module tb_coffe_dispenser;

  localparam int M = 4;
  localparam int E = 2;
  localparam int G = 1;
  localparam int R = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       out_en;
  logic [3:0] out;
  logic       change_en;
  logic [1:0] change;
  logic       return_req;
  logic [3:0] motor;
  logic       coin_eject;
  logic       escrow_gate;
  logic       busy;
  logic       done;
  logic       fault;

  coffe_dispenser #(
    .MOTOR_CYCLES (M),
    .EJECT_CYCLES (E),
    .GAP_CYCLES   (G),
    .ESCROW_CYCLES(R)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .out_en     (out_en),
    .out        (out),
    .change_en  (change_en),
    .change     (change),
    .return_req (return_req),
    .motor      (motor),
    .coin_eject (coin_eject),
    .escrow_gate(escrow_gate),
    .busy       (busy),
    .done       (done),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] motor;
    logic       eject;
    logic       escrow;
    logic       busy;
    logic       done;
    logic       fault;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] m, input logic ej, input logic es,
                              input logic dn);
    exp_t e;
    e.motor  = m;
    e.eject  = ej;
    e.escrow = es;
    e.busy   = 1'b1;
    e.done   = dn;
    e.fault  = 1'b0;
    return e;
  endfunction

  // Expand an accepted request into the list of output vectors it produces, one per cycle.
  task automatic plan(input logic oe, input logic [3:0] o, input logic ce,
                      input logic [1:0] c, input logic rt);
    int   n;
    bit   valid;
    exp_t first_fault;
    if (oe || ce) begin
      n     = ce ? int'(c) : 0;
      valid = oe && $onehot(o);
      if (valid) for (int i = 0; i < M; i++) q.push_back(mk(o, 1'b0, 1'b0, 1'b0));
      for (int k = 0; k < n; k++) begin
        for (int i = 0; i < E; i++) q.push_back(mk(4'b0, 1'b1, 1'b0, 1'b0));
        if (k < n - 1) for (int i = 0; i < G; i++) q.push_back(mk(4'b0, 1'b0, 1'b0, 1'b0));
      end
      q.push_back(mk(4'b0, 1'b0, 1'b0, 1'b1));
      if (oe && !valid) begin
        first_fault       = q[0];
        first_fault.fault = 1'b1;
        q[0]              = first_fault;
      end
    end else if (rt) begin
      for (int i = 0; i < R; i++) q.push_back(mk(4'b0, 1'b0, 1'b1, 1'b0));
      q.push_back(mk(4'b0, 1'b0, 1'b0, 1'b1));
    end
  endtask

  task automatic step(input logic r, input logic oe, input logic [3:0] o,
                      input logic ce, input logic [1:0] c, input logic rt);
    rst        = r;
    out_en     = oe;
    out        = o;
    change_en  = ce;
    change     = c;
    return_req = rt;
    if (r) begin
      q.delete();
    end else if (!cur.busy) begin
      plan(oe, o, ce, c, rt);
    end
    cur = (q.size() > 0) ? q.pop_front() : '0;
    @(posedge clk);
    @(negedge clk);
    check("motor", int'(motor), int'(cur.motor));
    check("coin_eject", int'(coin_eject), int'(cur.eject));
    check("escrow_gate", int'(escrow_gate), int'(cur.escrow));
    check("busy", int'(busy), int'(cur.busy));
    check("done", int'(done), int'(cur.done));
    check("fault", int'(fault), int'(cur.fault));
    check("exclusive", int'((motor != 4'b0) + coin_eject + escrow_gate) <= 1, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'b0, 1'b0, 2'd0, 1'b0);
  endtask

  initial begin
    logic       oe, ce, rt, r;
    logic [3:0] o;
    logic [1:0] c;
    cur = '0;
    @(negedge clk);
    step(1'b1, 1'b0, 4'b0, 1'b0, 2'd0, 1'b0);
    step(1'b1, 1'b1, 4'b0010, 1'b1, 2'd3, 1'b1);
    idle(3);

    step(1'b0, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0);
    idle(10);
    step(1'b0, 1'b1, 4'b1000, 1'b1, 2'd2, 1'b0);
    idle(14);
    step(1'b0, 1'b1, 4'b0110, 1'b1, 2'd1, 1'b0);
    idle(5);
    step(1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0);
    idle(3);
    step(1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1);
    idle(5);
    step(1'b0, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b1);
    idle(8);
    step(1'b0, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0);
    idle(1);
    step(1'b0, 1'b1, 4'b0100, 1'b1, 2'd3, 1'b1);
    idle(10);
    step(1'b0, 1'b1, 4'b0100, 1'b1, 2'd3, 1'b0);
    idle(2);
    step(1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
    step(1'b0, 1'b1, 4'b0001, 1'b1, 2'd2, 1'b0);
    idle(16);

    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 99) == 0);
      oe = ($urandom_range(0, 5) == 0);
      o  = ($urandom_range(0, 9) < 7) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      ce = oe ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
      c  = 2'($urandom_range(0, 3));
      rt = ($urandom_range(0, 9) == 0);
      step(r, oe, o, ce, c, rt);
    end
    idle(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
